// File: rtl/demux_pkg.sv
// Shared constants and helpers for the n-way stream demultiplexer.
package demux_pkg;

  // Largest channel count the demux supports.
  localparam int unsigned DEMUX_MAX_OUT = 16;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  // Select width, never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/demux_nway_stream_if.sv
// Producer-side and consumer-side handshake signals of the n-way demux.
interface demux_nway_stream_if
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NUM_OUT = 4
);

  localparam int unsigned SEL_W = sel_width(NUM_OUT);

  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W-1:0]         in_data;
  logic [SEL_W-1:0]          in_sel;
  logic                      in_bcast;
  logic [NUM_OUT-1:0]        out_valid;
  logic [NUM_OUT-1:0]        out_ready;
  logic [NUM_OUT*DATA_W-1:0] out_data;
  logic                      sel_err;

  // Environment side: drives the producer word and the consumer readies.
  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data, sel_err
  );

  // Demux side.
  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data, sel_err
  );

endinterface

// File: rtl/demux_slot.sv
// One-entry output holding register; load wins over drain so a same-cycle
// drain and fill keeps the slot full with the new word.
module demux_slot #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              drain,
  input  logic [DATA_W-1:0] load_data,
  output logic              full,
  output logic [DATA_W-1:0] data
);

  logic              full_q;
  logic [DATA_W-1:0] data_q;

  // Slot state: data only changes on load, so it holds while stalled or empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (load) begin
      full_q <= 1'b1;
      data_q <= load_data;
    end else if (drain) begin
      full_q <= 1'b0;
    end
  end

  assign full = full_q;
  assign data = data_q;

endmodule

// File: rtl/demux_nway_stream.sv
// Registered 1-to-NUM_OUT stream demux with per-channel holding slots,
// broadcast mode and an out-of-range select error pulse.
module demux_nway_stream
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NUM_OUT = 4
) (
  input logic                clk,
  input logic                rst_n,
  demux_nway_stream_if.slave bus
);

  if (NUM_OUT < 2 || NUM_OUT > DEMUX_MAX_OUT) begin : g_bad_num_out
    $error("demux_nway_stream: NUM_OUT must be within 2..16");
  end

  logic [NUM_OUT-1:0] full;
  logic [NUM_OUT-1:0] can_acc;
  logic [NUM_OUT-1:0] drain;
  logic [NUM_OUT-1:0] load;
  logic [NUM_OUT-1:0] sel_onehot;
  logic               sel_legal;
  logic               in_ready;
  logic               xfer;
  logic               sel_err_d;
  logic               sel_err_q;
  logic               slot_full [NUM_OUT];
  logic [DATA_W-1:0]  slot_data [NUM_OUT];

  // Select decode, ready generation and per-slot load/drain enables.
  always_comb begin
    sel_onehot = '0;
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      sel_onehot[k] = (32'(bus.in_sel) == k);
    end
    sel_legal = |sel_onehot;
    can_acc   = ~full | bus.out_ready;
    drain     = full & bus.out_ready;

    // Broadcast needs every slot free so all copies load on one edge;
    // an out-of-range select is swallowed unconditionally.
    if (bus.in_bcast) begin
      in_ready = &can_acc;
    end else if (!sel_legal) begin
      in_ready = 1'b1;
    end else begin
      in_ready = |(sel_onehot & can_acc);
    end

    xfer = bus.in_valid & in_ready;
    load = '0;
    if (xfer) begin
      load = bus.in_bcast ? '1 : sel_onehot;
    end
    sel_err_d = xfer & ~bus.in_bcast & ~sel_legal;
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
    demux_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[k]),
      .drain    (drain[k]),
      .load_data(bus.in_data),
      .full     (slot_full[k]),
      .data     (slot_data[k])
    );
  end

  // Pack slot state into the flat output bus.
  always_comb begin
    full         = '0;
    bus.out_data = '0;
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      full[k]                          = slot_full[k];
      bus.out_data[k*DATA_W +: DATA_W] = slot_data[k];
    end
  end

  // One-cycle error pulse per swallowed out-of-range word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = full;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_demux_nway_stream.sv
// Scoreboard bench for demux_nway_stream (DATA_W=16, NUM_OUT=5 so selects
// 5..7 are out of range).
module tb_demux_nway_stream;

  localparam int unsigned DW = 16;
  localparam int unsigned NO = 5;
  localparam int unsigned SW = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  demux_nway_stream_if #(.DATA_W(DW), .NUM_OUT(NO)) bus ();

  demux_nway_stream #(
    .DATA_W (DW),
    .NUM_OUT(NO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Reference model: words accepted but not yet delivered, per channel,
  // plus the last word loaded into each channel.
  logic [DW-1:0] exp_q [NO][$];
  logic [DW-1:0] last_data [NO];
  logic          err_nxt;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            n_acc = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NO; k++) begin
      exp_q[k].delete();
      last_data[k] = '0;
    end
    err_nxt = 1'b0;
  endtask

  // Monitor: compare outputs with the model and pop on every handshake.
  always @(negedge clk) begin
    logic [DW-1:0] got;
    if (rst_n) begin
      for (int k = 0; k < NO; k++) begin
        got = bus.out_data[k*DW +: DW];
        chk($sformatf("out_valid[%0d]", k), 32'(bus.out_valid[k]), 32'(exp_q[k].size() != 0));
        chk($sformatf("out_data[%0d]", k), 32'(got), 32'(last_data[k]));
        if (bus.out_valid[k] && bus.out_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL deliver[%0d]: got unexpected word %0h, expected none at %0t",
                     k, got, $time);
          end else begin
            chk($sformatf("deliver[%0d]", k), 32'(got), 32'(exp_q[k].pop_front()));
          end
        end
      end
      chk("sel_err", 32'(bus.sel_err), 32'(err_nxt));
    end
  end

  // One producer cycle: drive after the edge, check ready and update the
  // model late in the cycle (after the monitor has popped this cycle's drains).
  task automatic cyc(input logic v, input logic [SW-1:0] sel, input logic b,
                     input logic [DW-1:0] d, input logic [NO-1:0] rdy);
    logic exp_rdy;
    logic legal;
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_sel    = sel;
    bus.in_bcast  = b;
    bus.in_data   = d;
    bus.out_ready = rdy;
    @(negedge clk);
    #3;
    legal = (int'(sel) < NO);
    if (b) begin
      exp_rdy = 1'b1;
      for (int k = 0; k < NO; k++) begin
        if (exp_q[k].size() != 0) exp_rdy = 1'b0;
      end
    end else if (!legal) begin
      exp_rdy = 1'b1;
    end else begin
      exp_rdy = (exp_q[sel].size() == 0);
    end
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    err_nxt = 1'b0;
    if (v && exp_rdy) begin
      n_acc++;
      if (b) begin
        for (int k = 0; k < NO; k++) begin
          exp_q[k].push_back(d);
          last_data[k] = d;
        end
      end else if (legal) begin
        exp_q[sel].push_back(d);
        last_data[sel] = d;
      end else begin
        err_nxt = 1'b1;
      end
    end
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NO; k++) begin
      chk($sformatf("rst_valid[%0d]", k), 32'(bus.out_valid[k]), 32'd0);
      chk($sformatf("rst_data[%0d]", k), 32'(bus.out_data[k*DW +: DW]), 32'd0);
    end
    chk("rst_sel_err", 32'(bus.sel_err), 32'd0);
    model_clear();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int budget;
    bus.in_valid  = 1'b0;
    bus.in_sel    = '0;
    bus.in_bcast  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = '0;
    model_clear();
    do_reset();

    // Reset mid-traffic: ch0 holds 0xA5 under backpressure, then reset.
    cyc(1'b1, 3'd0, 1'b0, 16'h00A5, 5'b00000);
    cyc(1'b0, 3'd0, 1'b0, 16'h0000, 5'b00000);
    do_reset();
    cyc(1'b0, 3'd0, 1'b0, 16'h0000, 5'b11111);

    // Unicast route to ch2.
    cyc(1'b1, 3'd2, 1'b0, 16'h003C, 5'b11111);
    cyc(1'b0, 3'd0, 1'b0, 16'h0000, 5'b11111);
    cyc(1'b0, 3'd0, 1'b0, 16'h0000, 5'b11111);

    // Backpressure on ch1, then drain and refill on the same edge.
    cyc(1'b1, 3'd1, 1'b0, 16'h0011, 5'b11101);
    cyc(1'b1, 3'd1, 1'b0, 16'h0022, 5'b11101);
    cyc(1'b1, 3'd1, 1'b0, 16'h0022, 5'b11111);
    cyc(1'b0, 3'd0, 1'b0, 16'h0000, 5'b11111);
    cyc(1'b0, 3'd0, 1'b0, 16'h0000, 5'b11111);

    // Broadcast blocked by a full ch3, then released.
    cyc(1'b1, 3'd3, 1'b0, 16'h0055, 5'b10111);
    cyc(1'b1, 3'd0, 1'b1, 16'h007E, 5'b10111);
    cyc(1'b1, 3'd4, 1'b1, 16'h007E, 5'b10111);
    cyc(1'b1, 3'd0, 1'b1, 16'h007E, 5'b11111);
    cyc(1'b0, 3'd0, 1'b0, 16'h0000, 5'b11111);
    cyc(1'b0, 3'd0, 1'b0, 16'h0000, 5'b11111);

    // Out-of-range selects: single, then back-to-back.
    cyc(1'b1, 3'd5, 1'b0, 16'h0BAD, 5'b00000);
    cyc(1'b0, 3'd0, 1'b0, 16'h0000, 5'b11111);
    cyc(1'b1, 3'd7, 1'b0, 16'h1BAD, 5'b11111);
    cyc(1'b1, 3'd6, 1'b0, 16'h2BAD, 5'b11111);
    cyc(1'b0, 3'd0, 1'b0, 16'h0000, 5'b11111);
    cyc(1'b0, 3'd0, 1'b0, 16'h0000, 5'b11111);

    // Random streaming.
    n_acc  = 0;
    budget = 0;
    while (n_acc < 64 && budget < 3000) begin
      cyc(($urandom_range(0, 3) != 0), SW'($urandom_range(0, 5)),
          ($urandom_range(0, 11) == 0), DW'($urandom), NO'($urandom));
      budget++;
    end
    chk("stream_accepted", 32'(n_acc >= 64), 32'd1);

    // Drain everything and confirm nothing was lost.
    repeat (4) cyc(1'b0, 3'd0, 1'b0, 16'h0000, 5'b11111);
    for (int k = 0; k < NO; k++) begin
      chk($sformatf("residual[%0d]", k), 32'(exp_q[k].size()), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
